// File: rtl/pos_sweep_pkg.sv
// Shared types for the product-of-maxterms sweep checker: FSM states, legal
// parameter ranges and the in-flight vector tag.
package pos_sweep_pkg;

    localparam int N_MIN     = 1;
    localparam int N_MAX     = 8;
    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 8;
    localparam int TAG_IDX_W = N_MAX;
    localparam int MASK_MAX  = 1 << N_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] index;
    } tag_t;

    function automatic bit legal_cfg(input int n, input int lat);
        return (n >= N_MIN) && (n <= N_MAX) && (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    // Canonical product-of-maxterms value: the function is 0 exactly at the maxterms.
    function automatic logic canon_value(input logic [MASK_MAX-1:0] mask,
                                         input logic [TAG_IDX_W-1:0] k);
        return ~mask[k];
    endfunction

endpackage

// File: rtl/pos_tag_pipe.sv
// LAT-stage shift register carrying {valid, index} tags alongside the external
// DUT's latency; cleared by reset or by a flush request.
module pos_tag_pipe
    import pos_sweep_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  tag_t in_tag,
    output tag_t out_tag,
    output logic any_valid
);

    tag_t stages [LAT];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < LAT; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_tag = stages[LAT-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_valid = any_valid | stages[i].valid;
        end
    end

endmodule

// File: rtl/pos_sweep_checker.sv
// Truth-table sweeper comparing an external DUT against a product of maxterms.
// Optional build macro POS_SWEEP_STOP_ON_FAIL_EN aborts the sweep on the first mismatch.
module pos_sweep_checker
    import pos_sweep_pkg::*;
#(
    parameter int N   = 3,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [(1<<N)-1:0] maxterms,
    output logic [N-1:0]      stim,
    output logic              stim_valid,
    input  logic              dut_s,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N:0]        err_count,
    output logic [N-1:0]      first_err,
    output logic              first_err_valid,
    output state_t            dbg_state
);

    localparam int         NV       = 1 << N;
    localparam logic [N:0] LAST_IDX = (N+1)'(NV - 1);
    localparam logic [N:0] ERR_MAX  = (N+1)'(NV);
    localparam bit         CFG_OK   = legal_cfg(N, LAT);

    state_t              state, state_next;
    logic [N:0]          idx, idx_next;
    logic [NV-1:0]       mask_q;
    logic [MASK_MAX-1:0] mask_ext;
    tag_t                in_tag, out_tag;
    logic                pipe_any_valid;
    logic                flush;
    logic                mismatch;
    logic                clear_results;
    logic [N:0]          err_next;

    // Handshake: start is a one-cycle request honoured only in IDLE; stim_valid
    // qualifies stim for one cycle per vector and the DUT has no backpressure.

    always_comb begin
        mask_ext         = '0;
        mask_ext[NV-1:0] = mask_q;
    end

    assign mismatch = out_tag.valid && (dut_s != canon_value(mask_ext, out_tag.index));

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        flush         = 1'b0;
        clear_results = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && CFG_OK) begin
                    state_next    = ST_RUN;
                    idx_next      = '0;
                    clear_results = 1'b1;
                end
            end
            ST_RUN: begin
                if (idx == LAST_IDX) begin
                    state_next = ST_DRAIN;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!pipe_any_valid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
`ifdef POS_SWEEP_STOP_ON_FAIL_EN
        if (mismatch && ((state == ST_RUN) || (state == ST_DRAIN))) begin
            state_next = ST_DONE;
            flush      = 1'b1;
        end
`endif
    end

    // Tags are launched one edge ahead so the last pipe stage lines up with the
    // cycle in which the DUT response for that vector is sampled.
    always_comb begin
        in_tag.valid = (state_next == ST_RUN);
        in_tag.index = TAG_IDX_W'(idx_next);
    end

    always_comb begin
        if (clear_results) begin
            err_next = '0;
        end else if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + 1'b1;
        end else begin
            err_next = err_count;
        end
    end

    pos_tag_pipe #(
        .LAT(LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_tag   (in_tag),
        .out_tag  (out_tag),
        .any_valid(pipe_any_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            idx             <= '0;
            mask_q          <= '0;
            err_count       <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            err_count <= err_next;
            if (clear_results) begin
                mask_q          <= maxterms;
                first_err       <= '0;
                first_err_valid <= 1'b0;
                pass            <= 1'b0;
            end else if (mismatch && !first_err_valid) begin
                first_err       <= N'(out_tag.index);
                first_err_valid <= 1'b1;
            end
            if ((state_next == ST_DONE) && (state != ST_DONE)) begin
                pass <= (err_next == '0);
            end
        end
    end

    assign stim       = idx[N-1:0];
    assign stim_valid = (state == ST_RUN);
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_pos_sweep_checker.sv
// Bench for pos_sweep_checker: one instance with a combinational DUT model (LAT=1)
// and one with a two-register DUT model (LAT=3), checked against a scoreboard.
module tb_pos_sweep_checker;
    import pos_sweep_pkg::*;

    localparam int N     = 3;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_v         [2];
    logic [7:0] maxterms_v      [2];
    logic [2:0] stim_v          [2];
    logic       stim_valid_v    [2];
    logic       busy_v          [2];
    logic       done_v          [2];
    logic       pass_v          [2];
    logic [3:0] err_v           [2];
    logic [2:0] ferr_v          [2];
    logic       fev_v           [2];
    state_t     dbg_v           [2];
    logic       dut_s_a, dut_s_b;
    logic       d1_b, d2_b;

    logic [1:0] mode_v  [2];
    logic [7:0] mmask_v [2];
    logic [7:0] flip_v  [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q  [$];
    logic [2:0] stim_q [$];

    always #5 clk = ~clk;

    pos_sweep_checker #(.N(N), .LAT(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .maxterms(maxterms_v[0]),
        .stim(stim_v[0]), .stim_valid(stim_valid_v[0]), .dut_s(dut_s_a),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .first_err(ferr_v[0]), .first_err_valid(fev_v[0]), .dbg_state(dbg_v[0])
    );

    pos_sweep_checker #(.N(N), .LAT(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .maxterms(maxterms_v[1]),
        .stim(stim_v[1]), .stim_valid(stim_valid_v[1]), .dut_s(dut_s_b),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .first_err(ferr_v[1]), .first_err_valid(fev_v[1]), .dbg_state(dbg_v[1])
    );

    // External function models: 0 ideal, 1 (x|y|z)&(~x|~y), 2 ~z, 3 ideal with flipped rows.
    function automatic logic model_out(input logic [1:0] mode, input logic [7:0] mmask,
                                       input logic [7:0] flip, input logic [2:0] k);
        logic x, y, z;
        x = k[2]; y = k[1]; z = k[0];
        case (mode)
            2'd0:    return ~mmask[k];
            2'd1:    return (x | y | z) & (~x | ~y);
            2'd2:    return ~z;
            default: return ~mmask[k] ^ flip[k];
        endcase
    endfunction

    always_comb dut_s_a = model_out(mode_v[0], mmask_v[0], flip_v[0], stim_v[0]);

    always @(posedge clk) begin
        d1_b <= model_out(mode_v[1], mmask_v[1], flip_v[1], stim_v[1]);
        d2_b <= d1_b;
    end
    assign dut_s_b = d2_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input int sel, input string pfx);
        check({pfx, "_stim"},       32'(stim_v[sel]), 0);
        check({pfx, "_stim_valid"}, 32'(stim_valid_v[sel]), 0);
        check({pfx, "_busy"},       32'(busy_v[sel]), 0);
        check({pfx, "_done"},       32'(done_v[sel]), 0);
        check({pfx, "_pass"},       32'(pass_v[sel]), 0);
        check({pfx, "_err_count"},  32'(err_v[sel]), 0);
        check({pfx, "_first_err"},  32'(ferr_v[sel]), 0);
        check({pfx, "_first_valid"},32'(fev_v[sel]), 0);
        check({pfx, "_state"},      32'(dbg_v[sel]), 32'(ST_IDLE));
    endtask

    task automatic run_sweep(input int sel, input logic [7:0] mask, input logic [1:0] mode,
                             input logic [7:0] flip, input bit late_start);
        int lat, cnt, first, span, nvalid, done_cyc, busy_cnt;
        bit seen_done;
        logic [8:0] exp_r;
        lat   = (sel == 0) ? LAT_A : LAT_B;
        cnt   = 0;
        first = -1;
        for (int k = 0; k < 8; k++) begin
            if (model_out(mode, mask, flip, 3'(k)) !== ~mask[k]) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        span = 8 + lat;
`ifdef POS_SWEEP_STOP_ON_FAIL_EN
        if (cnt > 0) begin
            cnt  = 1;
            span = first + lat;
        end
`endif
        exp_q.push_back({cnt == 0, first >= 0, 3'((first < 0) ? 0 : first), 4'(cnt)});
        nvalid = (span < 8) ? span : 8;
        for (int k = 0; k < nvalid; k++) stim_q.push_back(3'(k));

        mode_v[sel]  = mode;
        mmask_v[sel] = mask;
        flip_v[sel]  = flip;
        @(negedge clk);
        start_v[sel]    = 1'b1;
        maxterms_v[sel] = mask;
        @(negedge clk);
        start_v[sel] = 1'b0;
        done_cyc  = -1;
        busy_cnt  = 0;
        seen_done = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (stim_valid_v[sel]) begin
                if (stim_q.size() > 0) check("stim", 32'(stim_v[sel]), 32'(stim_q.pop_front()));
                else check("stim_extra", 1, 0);
            end
            if (busy_v[sel]) busy_cnt++;
            if (done_v[sel]) begin
                done_cyc  = cyc;
                seen_done = 1'b1;
                break;
            end
            if (late_start && cyc == 5) begin
                start_v[sel]    = 1'b1;
                maxterms_v[sel] = ~mask;
            end else begin
                start_v[sel] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[sel] = 1'b0;
        check("done_seen", 32'(seen_done), 1);
        check("done_cycle", 32'(done_cyc), 32'(span + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(span));
        check("stim_left", 32'(stim_q.size()), 0);
        stim_q.delete();
        exp_r = exp_q.pop_front();
        check("err_count", 32'(err_v[sel]), 32'(exp_r[3:0]));
        check("first_err", 32'(ferr_v[sel]), 32'(exp_r[6:4]));
        check("first_valid", 32'(fev_v[sel]), 32'(exp_r[7]));
        check("pass", 32'(pass_v[sel]), 32'(exp_r[8]));
        @(negedge clk);
        check("done_pulse", 32'(done_v[sel]), 0);
        check("busy_after", 32'(busy_v[sel]), 0);
        check("err_hold", 32'(err_v[sel]), 32'(exp_r[3:0]));
        check("pass_hold", 32'(pass_v[sel]), 32'(exp_r[8]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; maxterms_v[i] = '0;
            mode_v[i] = 2'd0; mmask_v[i] = '0; flip_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_outputs_zero(0, "rst_a");
        check_outputs_zero(1, "rst_b");
        reset = 1'b0;
        @(negedge clk);

        run_sweep(0, 8'hC4, 2'd0, 8'h00, 1'b0);
        run_sweep(0, 8'hC4, 2'd1, 8'h00, 1'b0);
        run_sweep(0, 8'h3A, 2'd2, 8'h00, 1'b0);
        run_sweep(1, 8'hC4, 2'd0, 8'h00, 1'b1);
        run_sweep(1, 8'h3A, 2'd2, 8'h00, 1'b0);

        // Reset in the middle of a sweep on the combinational instance.
        mode_v[0] = 2'd0; mmask_v[0] = 8'hC4; flip_v[0] = 8'h00;
        @(negedge clk);
        start_v[0] = 1'b1; maxterms_v[0] = 8'hC4;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero(0, "midrst");
        reset = 1'b0;
        run_sweep(0, 8'hC4, 2'd0, 8'h00, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [7:0] fl;
            fl = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            run_sweep($urandom_range(0, 1), 8'($urandom_range(0, 255)), 2'd3, fl, r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
